// File: rtl/sdram_copy_csr.sv
// Avalon-MM register front-end for the sdram_master word-copy engine.
// Holds job parameters, launches the engine and tracks completion, status and statistics.
module sdram_copy_csr #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   input  logic [31:0] slave_writedata,
   output logic [31:0] slave_readdata,
   output logic        slave_waitrequest,
   output logic [31:0] dest_addr,
   output logic [31:0] src_addr,
   output logic [31:0] num_words,
   output logic        enable,
   input  logic        copying,
   output logic        irq
);

   typedef enum logic [1:0] {StIdle, StKick, StAck, StRun} state_e;

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [31:0]        dest_q, dest_d, src_q, src_d, numw_q, numw_d;
   logic               done_q, done_d, err_q, err_d, irq_en_q, irq_en_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d, jobs_q, jobs_d;
   logic               rd_pend_q, rd_pend_d;
   logic [31:0]        rdata_q, rdata_d, rd_mux;

   logic busy, wr_ctrl, wr_param, start, clr, kick, zero_job, job_end, rd_req;

   assign busy     = (state_q != StIdle);
   assign wr_ctrl  = slave_write && (slave_address == 3'd0);
   assign wr_param = slave_write && (slave_address >= 3'd1) && (slave_address <= 3'd3);
   assign start    = wr_ctrl && slave_writedata[0];
   assign clr      = wr_ctrl && slave_writedata[1];
   assign kick     = !busy && start && (numw_q != 32'd0);
   // The engine always copies at least one word, so an empty job completes without it.
   assign zero_job = !busy && start && (numw_q == 32'd0);
   assign job_end  = (state_q == StRun) && !copying;
   assign rd_req   = slave_read && !slave_write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (kick) state_d = StKick;
         StKick: state_d = StAck;
         StAck:  if (copying) state_d = StRun;
         StRun:  if (!copying) state_d = StIdle;
      endcase
   end

   always_comb begin
      enable = (state_q == StKick);
   end

   always_comb begin
      dest_d = dest_q;
      src_d  = src_q;
      numw_d = numw_q;
      if (slave_write && !busy) begin
         case (slave_address)
            3'd1:    dest_d = slave_writedata;
            3'd2:    src_d  = slave_writedata;
            3'd3:    numw_d = slave_writedata;
            default: ;
         endcase
      end
      // Clear takes effect before any set in the same cycle.
      done_d   = clr ? 1'b0 : done_q;
      err_d    = clr ? 1'b0 : err_q;
      irq_en_d = wr_ctrl ? slave_writedata[2] : irq_en_q;
      if (busy && (start || wr_param)) err_d = 1'b1;
      if (zero_job || job_end) done_d = 1'b1;
      jobs_d = (zero_job || job_end) ? jobs_q + CntOne : jobs_q;
      cycles_d = cycles_q;
      if (kick) begin
         cycles_d = '0;
      end else if (busy && !job_end && (cycles_q != '1)) begin
         cycles_d = cycles_q + CntOne;
      end
   end

   always_comb begin
      case (slave_address)
         3'd0:    rd_mux = {28'd0, irq_en_q, err_q, done_q, busy};
         3'd1:    rd_mux = dest_q;
         3'd2:    rd_mux = src_q;
         3'd3:    rd_mux = numw_q;
         3'd4:    rd_mux = 32'(cycles_q);
         3'd5:    rd_mux = 32'(jobs_q);
         default: rd_mux = 32'd0;
      endcase
      rd_pend_d = rd_req && !rd_pend_q;
      rdata_d   = rd_pend_d ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dest_q    <= '0;
         src_q     <= '0;
         numw_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         irq_en_q  <= 1'b0;
         cycles_q  <= '0;
         jobs_q    <= '0;
         rd_pend_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         dest_q    <= dest_d;
         src_q     <= src_d;
         numw_q    <= numw_d;
         done_q    <= done_d;
         err_q     <= err_d;
         irq_en_q  <= irq_en_d;
         cycles_q  <= cycles_d;
         jobs_q    <= jobs_d;
         rd_pend_q <= rd_pend_d;
         rdata_q   <= rdata_d;
      end
   end

   assign slave_waitrequest = rd_req && !rd_pend_q;
   assign slave_readdata    = rdata_q;
   assign dest_addr         = dest_q;
   assign src_addr          = src_q;
   assign num_words         = numw_q;
   assign irq               = done_q && irq_en_q;

endmodule
